// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: shared types and defaults for the clock-source switch.
// Optional feature macro used by clk_switch_ctrl: CLK_SWITCH_AUTO_FAILOVER_EN.
package clk_switch_pkg;

    localparam int MAX_SRC            = 16;
    localparam int DEF_GATE_OFF_CYC   = 4;
    localparam int DEF_MUX_SETTLE_CYC = 8;
    localparam int DEF_CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE_OFF,
        ST_SWITCH,
        ST_SETTLE,
        ST_GATE_ON
    } state_e;

    // One-hot vector for idx; all-zero when idx is outside 0..n-1.
    function automatic logic [MAX_SRC-1:0] onehot(input logic [3:0] idx,
                                                  input int n);
        logic [MAX_SRC-1:0] v;
        v = '0;
        if (int'(idx) < n) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/clk_switch_cnt.sv
// clk_switch_cnt: loadable down-counter for the gate-off and settle windows.
// zero flags that the count is (or becomes, on this decrement) zero.
module clk_switch_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             func_rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (func_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0) || (dec && cnt_q == CNT_W'(1));

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences clock-source changes (gate off, mux, settle, gate on).
// Define CLK_SWITCH_AUTO_FAILOVER_EN to fail over to RST_SRC on source loss.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter  int N_SRC          = 3,
    localparam int SEL_W          = $clog2(N_SRC),
    parameter  int RST_SRC        = 0,
    parameter  int GATE_OFF_CYC   = DEF_GATE_OFF_CYC,
    parameter  int MUX_SETTLE_CYC = DEF_MUX_SETTLE_CYC,
    parameter  int CNT_W          = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             func_rst,
    input  logic             req_vld,
    input  logic [SEL_W-1:0] req_src,
    output logic             req_rdy,
    input  logic [N_SRC-1:0] src_ok,
    output logic [N_SRC-1:0] cg_en,
    output logic [SEL_W-1:0] clkmux_sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    if (N_SRC < 2 || N_SRC > MAX_SRC || RST_SRC < 0 || RST_SRC >= N_SRC)
    begin : g_src_chk
        $error("clk_switch_ctrl: bad N_SRC/RST_SRC");
    end
    if (GATE_OFF_CYC < 1 || MUX_SETTLE_CYC < 1 ||
        GATE_OFF_CYC >= 2**CNT_W || MUX_SETTLE_CYC >= 2**CNT_W)
    begin : g_cyc_chk
        $error("clk_switch_ctrl: cycle count does not fit CNT_W");
    end

    localparam int               NP      = 2**SEL_W;
    localparam logic [SEL_W-1:0] RST_V   = SEL_W'(RST_SRC);
    localparam logic [SEL_W:0]   NSRC_V  = (SEL_W+1)'(N_SRC);
    localparam logic [N_SRC-1:0] RST_OH  = N_SRC'(onehot(4'(RST_V), N_SRC));

    state_e           state;
    logic [SEL_W-1:0] cur;
    logic [SEL_W-1:0] tgt;
    logic [NP-1:0]    ok_ext;
    logic             req_ok;
    logic             fail_go;
    logic             start;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign ok_ext = NP'(src_ok);
    assign req_ok = ({1'b0, req_src} < NSRC_V) && ok_ext[req_src];

`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
    assign fail_go = (state == ST_IDLE) && !ok_ext[cur] &&
                     (cur != RST_V) && ok_ext[RST_V];
`else
    assign fail_go = 1'b0;
`endif

    assign req_rdy = (state == ST_IDLE) && !fail_go;
    assign busy    = !req_rdy;

    assign start    = fail_go ||
                      (req_rdy && req_vld && req_ok && req_src != cur);
    assign cnt_load = start || (state == ST_SWITCH);
    assign cnt_dec  = (state == ST_GATE_OFF) || (state == ST_SETTLE);
    assign cnt_val  = (state == ST_SWITCH) ? CNT_W'(MUX_SETTLE_CYC)
                                           : CNT_W'(GATE_OFF_CYC);

    clk_switch_cnt #(
        .CNT_W    (CNT_W)
    ) u_cnt (
        .clk      (sys_clk),
        .func_rst (func_rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Switch sequencer with registered gate enables, mux select and pulses.
    always_ff @(posedge sys_clk) begin
        if (func_rst) begin
            state      <= ST_IDLE;
            cur        <= RST_V;
            tgt        <= RST_V;
            clkmux_sel <= RST_V;
            cg_en      <= RST_OH;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cg_en <= ok_ext[cur] ? N_SRC'(onehot(4'(cur), N_SRC))
                                         : '0;
                    if (fail_go) begin
                        tgt   <= RST_V;
                        cg_en <= '0;
                        err   <= 1'b1;
                        state <= ST_GATE_OFF;
                    end else if (req_vld) begin
                        if (!req_ok) begin
                            err <= 1'b1;
                        end else if (req_src == cur) begin
                            done <= 1'b1;
                        end else begin
                            tgt   <= req_src;
                            cg_en <= '0;
                            state <= ST_GATE_OFF;
                        end
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt_zero) state <= ST_SWITCH;
                end
                ST_SWITCH: begin
                    clkmux_sel <= tgt;
                    cur        <= tgt;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state <= ST_GATE_ON;
                        if (ok_ext[tgt]) begin
                            cg_en <= N_SRC'(onehot(4'(tgt), N_SRC));
                            done  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_GATE_ON: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: randomized self-checking bench for clk_switch_ctrl.
// Expected timelines come from the cycle rules (G gate-off, M settle cycles).
module tb_clk_switch_ctrl;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int G  = 4;
    localparam int M  = 8;

    logic          sys_clk = 1'b0;
    logic          func_rst;
    logic          req_vld;
    logic [SW-1:0] req_src;
    logic          req_rdy;
    logic [N-1:0]  src_ok;
    logic [N-1:0]  cg_en;
    logic [SW-1:0] clkmux_sel;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int m_cur  = 0;

    always #5 sys_clk = ~sys_clk;

    clk_switch_ctrl #(
        .N_SRC          (N),
        .RST_SRC        (0),
        .GATE_OFF_CYC   (G),
        .MUX_SETTLE_CYC (M),
        .CNT_W          (8)
    ) dut (
        .sys_clk    (sys_clk),
        .func_rst   (func_rst),
        .req_vld    (req_vld),
        .req_src    (req_src),
        .req_rdy    (req_rdy),
        .src_ok     (src_ok),
        .cg_en      (cg_en),
        .clkmux_sel (clkmux_sel),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick_other(int avoid);
        int t;
        do t = int'($urandom_range(N-1)); while (t == avoid);
        return t;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Full switch from m_cur to t, request raised in the current cycle (0).
    task automatic run_switch(int t);
        int old;
        logic [N-1:0] e_cg;
        int e_sel;
        logic e_done, e_rdy;
        old = m_cur;
        req_vld = 1'b1;
        req_src = SW'(t);
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL switch_accept: req_rdy=%b want 1", req_rdy);
        end
        for (int c = 1; c <= G + M + 3; c++) begin
            tick();
            if (c == 1) req_vld = 1'b0;
            e_cg   = (c >= G + M + 2) ? oh(t) : '0;
            e_sel  = (c >= G + 2) ? t : old;
            e_done = (c == G + M + 2);
            e_rdy  = (c >= G + M + 3);
            checks++;
            if (cg_en !== e_cg || clkmux_sel !== SW'(e_sel) ||
                done !== e_done || err !== 1'b0 ||
                req_rdy !== e_rdy || busy !== !e_rdy) begin
                errors++;
                $display("FAIL switch %0d->%0d c=%0d: cg=%b sel=%0d done=%b err=%b rdy=%b busy=%b, want cg=%b sel=%0d done=%b err=0 rdy=%b",
                         old, t, c, cg_en, clkmux_sel, done, err, req_rdy,
                         busy, e_cg, e_sel, e_done, e_rdy);
            end
        end
        m_cur = t;
    endtask

    task automatic test_reset();
        func_rst = 1'b1;
        req_vld  = 1'b0;
        req_src  = '0;
        src_ok   = '1;
        tick();
        tick();
        checks++;
        if (cg_en !== 3'b001 || clkmux_sel !== 2'd0 || req_rdy !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cg=%b sel=%0d rdy=%b busy=%b done=%b err=%b, want 001 0 1 0 0 0",
                     cg_en, clkmux_sel, req_rdy, busy, done, err);
        end
        func_rst = 1'b0;
        tick();
        checks++;
        if (cg_en !== 3'b001 || clkmux_sel !== 2'd0 || req_rdy !== 1'b1 ||
            done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cg=%b sel=%0d rdy=%b done=%b err=%b, want 001 0 1 0 0",
                     cg_en, clkmux_sel, req_rdy, done, err);
        end
        m_cur = 0;
    endtask

    task automatic test_switch();
        run_switch(2);
        repeat (4) run_switch(pick_other(m_cur));
    endtask

    task automatic test_reject();
        int s;
        repeat (6) begin
            if ($urandom_range(1) == 0) begin
                s = 3;
            end else begin
                s = pick_other(m_cur);
                src_ok[s] = 1'b0;
            end
            req_vld = 1'b1;
            req_src = SW'(s);
            tick();
            req_vld = 1'b0;
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || cg_en !== oh(m_cur) ||
                clkmux_sel !== SW'(m_cur) || req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL reject src=%0d: err=%b done=%b cg=%b sel=%0d rdy=%b, want 1 0 %b %0d 1",
                         s, err, done, cg_en, clkmux_sel, req_rdy,
                         oh(m_cur), m_cur);
            end
            tick();
            checks++;
            if (err !== 1'b0 || req_rdy !== 1'b1 || cg_en !== oh(m_cur)) begin
                errors++;
                $display("FAIL reject_after: err=%b rdy=%b cg=%b, want 0 1 %b",
                         err, req_rdy, cg_en, oh(m_cur));
            end
            src_ok = '1;
        end
    endtask

    task automatic test_same();
        req_vld = 1'b1;
        req_src = SW'(m_cur);
        tick();
        req_vld = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || req_rdy !== 1'b1 ||
            cg_en !== oh(m_cur) || clkmux_sel !== SW'(m_cur)) begin
            errors++;
            $display("FAIL same_src: done=%b err=%b rdy=%b cg=%b sel=%0d, want 1 0 1 %b %0d",
                     done, err, req_rdy, cg_en, clkmux_sel, oh(m_cur), m_cur);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL same_src_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_settle_drop();
        int t;
        t = pick_other(m_cur);
        req_vld = 1'b1;
        req_src = SW'(t);
        for (int c = 1; c <= G + M + 3; c++) begin
            tick();
            if (c == 1) req_vld = 1'b0;
            if (c == G + 4) src_ok[t] = 1'b0;
            if (c == G + M + 2) begin
                checks++;
                if (err !== 1'b1 || done !== 1'b0 || cg_en !== '0 ||
                    clkmux_sel !== SW'(t)) begin
                    errors++;
                    $display("FAIL settle_drop: err=%b done=%b cg=%b sel=%0d, want 1 0 000 %0d",
                             err, done, cg_en, clkmux_sel, t);
                end
            end
        end
        checks++;
        if (req_rdy !== 1'b1 || cg_en !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL settle_drop_idle: rdy=%b cg=%b err=%b, want 1 000 0",
                     req_rdy, cg_en, err);
        end
        m_cur = t;
        src_ok = '1;
        tick();
        checks++;
        if (cg_en !== oh(t)) begin
            errors++;
            $display("FAIL settle_drop_restore: cg=%b want %b", cg_en, oh(t));
        end
    endtask

    task automatic test_back_to_back();
        int a, b;
        a = pick_other(m_cur);
        b = pick_other(a);
        req_vld = 1'b1;
        req_src = SW'(a);
        for (int c = 1; c <= G + M + 2; c++) begin
            tick();
            if (c == 1) req_src = SW'(b);
            checks++;
            if (req_rdy !== 1'b0 || done !== (c == G + M + 2)) begin
                errors++;
                $display("FAIL b2b_busy c=%0d: rdy=%b done=%b, want 0 %b",
                         c, req_rdy, done, (c == G + M + 2));
            end
        end
        tick();
        checks++;
        if (cg_en !== oh(a) || clkmux_sel !== SW'(a)) begin
            errors++;
            $display("FAIL b2b_first: cg=%b sel=%0d, want %b %0d",
                     cg_en, clkmux_sel, oh(a), a);
        end
        m_cur = a;
        run_switch(b);
    endtask

    task automatic test_midreset();
        func_rst = 1'b1;
        tick();
        func_rst = 1'b0;
        m_cur = 0;
        req_vld = 1'b1;
        req_src = 2'd2;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req_vld = 1'b0;
        end
        func_rst = 1'b1;
        tick();
        func_rst = 1'b0;
        checks++;
        if (cg_en !== 3'b001 || clkmux_sel !== 2'd0 || req_rdy !== 1'b1 ||
            done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset: cg=%b sel=%0d rdy=%b done=%b err=%b, want 001 0 1 0 0",
                     cg_en, clkmux_sel, req_rdy, done, err);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || err !== 1'b0 || cg_en !== 3'b001 ||
                req_rdy !== 1'b1) begin
                errors++;
                $display("FAIL midreset_quiet c=%0d: done=%b err=%b cg=%b rdy=%b",
                         c, done, err, cg_en, req_rdy);
            end
        end
    endtask

    task automatic test_src_loss();
        int c0;
        if (m_cur == 0) run_switch(1 + int'($urandom_range(1)));
        c0 = m_cur;
        src_ok[c0] = 1'b0;
`ifdef CLK_SWITCH_AUTO_FAILOVER_EN
        for (int c = 1; c <= G + M + 3; c++) begin
            tick();
            checks++;
            if (err !== (c == 1) || done !== (c == G + M + 2) ||
                req_rdy !== (c >= G + M + 3) ||
                cg_en !== ((c >= G + M + 2) ? 3'b001 : 3'b000) ||
                clkmux_sel !== SW'((c >= G + 2) ? 0 : c0)) begin
                errors++;
                $display("FAIL failover c=%0d: err=%b done=%b rdy=%b cg=%b sel=%0d",
                         c, err, done, req_rdy, cg_en, clkmux_sel);
            end
        end
        m_cur = 0;
        src_ok = '1;
        tick();
`else
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (cg_en !== '0 || err !== 1'b0 || done !== 1'b0 ||
                req_rdy !== 1'b1 || clkmux_sel !== SW'(c0)) begin
                errors++;
                $display("FAIL src_loss c=%0d: cg=%b err=%b done=%b rdy=%b sel=%0d, want 000 0 0 1 %0d",
                         c, cg_en, err, done, req_rdy, clkmux_sel, c0);
            end
        end
        src_ok = '1;
        tick();
        checks++;
        if (cg_en !== oh(c0)) begin
            errors++;
            $display("FAIL src_restore: cg=%b want %b", cg_en, oh(c0));
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_switch();
        test_reject();
        test_same();
        test_settle_drop();
        test_back_to_back();
        test_same();
        test_src_loss();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Parametrised clock-source switch controller for the clock-gating/muxing subsystem. Generalises the fixed PLL/OSC/EXT gate-and-mux arrangement to N_SRC sources and sequences every source change in hardware: gate off, move mux select, settle, gate on. It runs entirely in the always-on `sys_clk` domain and drives the per-source clock-gate enables and the glitch-safe clock mux select.

## Interface
- N_SRC, 3, number of clock sources (2..16)
- SEL_W, $clog2(N_SRC), select width (derived, not overridden)
- RST_SRC, 0, source selected and enabled out of reset; failover target
- GATE_OFF_CYC, 4, cycles all gates held off before mux change (>=1)
- MUX_SETTLE_CYC, 8, cycles after mux change before gate re-enable (>=1)
- CNT_W, 8, settle counter width; elaboration error if either *_CYC >= 2**CNT_W

- sys_clk  in  1  controller clock, free-running
- func_rst  in  1  synchronous, active-high reset
- req_vld  in  1  switch request valid
- req_src  in  SEL_W  requested source index
- req_rdy  out  1  request accepted when req_vld && req_rdy
- src_ok  in  N_SRC  per-source alive/locked status, already synchronised
- cg_en  out  N_SRC  per-source clock-gate enables, at most one high
- clkmux_sel  out  SEL_W  clock mux select
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, switch completed
- err  out  1  one-cycle pulse, request rejected or target failed

## Operation
- States: IDLE, GATE_OFF, SWITCH, SETTLE, GATE_ON. req_rdy = (state==IDLE); busy = !req_rdy.
- Reset values: state IDLE, clkmux_sel=RST_SRC, cg_en=onehot(RST_SRC), done=0, err=0, counter 0, cur=RST_SRC.
- IDLE, request accepted:
  - req_src >= N_SRC or !src_ok[req_src]: err pulse, remain IDLE, no output change.
  - req_src == cur: done pulse, no sequence.
  - Otherwise: latch target, clear all cg_en, load GATE_OFF_CYC, go to GATE_OFF.
- GATE_OFF: decrement; on reaching 0 go to SWITCH.
- SWITCH: clkmux_sel <= target, cur <= target, load MUX_SETTLE_CYC, go to SETTLE.
- SETTLE: decrement; on reaching 0 go to GATE_ON.
- GATE_ON: one cycle. If src_ok[target]: cg_en=onehot(target), done=1. Else cg_en stays 0 and err=1. Go to IDLE.
- IDLE source loss: !src_ok[cur] clears cg_en[cur] next cycle. It is restored the cycle after src_ok[cur] returns, unless a sequence has started.
- req_vld while busy is ignored. The requester holds req_vld until accepted.
- func_rst mid-sequence: next edge forces all reset values. The sequence is abandoned and no done/err is issued.
- done and err are never high in the same cycle.

## Timing
- Acceptance edge ends cycle 0. cg_en is all-zero from cycle 1.
- GATE_OFF occupies cycles 1..G. SWITCH occupies cycle G+1. New clkmux_sel is visible from cycle G+2.
- SETTLE occupies cycles G+2..G+M+1. GATE_ON with cg_en/done occurs in cycle G+M+2. req_rdy returns high in cycle G+M+3.
- Default latency: done in cycle 14, next accept possible in cycle 15.
- err/done for rejected or same-source requests: cycle 1. req_rdy stays high throughout.
- All outputs are registered except req_rdy and busy, which decode directly from state.

## Configuration
- CLK_SWITCH_AUTO_FAILOVER_EN defined: in IDLE, if !src_ok[cur] && cur!=RST_SRC && src_ok[RST_SRC], the controller starts a normal sequence to RST_SRC on its own. This takes priority over a same-cycle req_vld, which is not accepted. err pulses in the cycle the failover starts.
- Undefined: source loss only gates off cg_en[cur]. Recovery is software-requested.

## Structure
- clk_switch_pkg holds the state enum, an onehot(idx, N) function, and the default cycle constants.
- Sub-module clk_switch_cnt is a loadable down-counter with CNT_W width, load/dec inputs and a zero flag. It is instantiated once.
- Top level contains the FSM, the target/cur registers and the output registers.

## Test plan
- Reset release (N_SRC=3, RST_SRC=0) -> cg_en=3'b001, clkmux_sel=0, req_rdy=1, done=err=0.
- Request src 2 with all src_ok=1 -> cg_en=0 from cycle 1, clkmux_sel=2 at cycle 6, cg_en=3'b100 and done at cycle 14, req_rdy high at 15.
- Request src 3 (out of range) or src 1 with src_ok[1]=0 -> err pulse in cycle 1, outputs unchanged. Request src==cur -> done in cycle 1.
- src_ok[target] dropped during SETTLE -> clkmux_sel=target, cg_en=0, err pulse in cycle 14. Back-to-back req_vld during busy -> not accepted until cycle 15.
- func_rst asserted in cycle 7 of a switch to src 2 -> next cycle cg_en=3'b001, clkmux_sel=0, IDLE, no done.
- Macro defined, cur=2, src_ok[2] drops -> err, failover sequence to 0, done 14 cycles later. Macro undefined -> cg_en[2]=0 only, no sequence.
